// File: rtl/cpu_uart.sv
// Byte UART on the internal I/O bus: TX shifter, RX with 2-flop sync, RX buffer, sticky flags.
// Optional macro UART_RX_FIFO_EN selects a FIFO_DEPTH-entry RX FIFO instead of a single holding register.
module cpu_uart #(
  parameter logic [15:0] DIV_RESET  = 16'd103,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  input  logic       re,
  output logic [7:0] rdata,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [15:0] div_q;
  logic [7:0]  rdata_q, rdata_d;
  logic        irq_q, ferr_q, ovr_q;
  logic        wr_data, rd_data, rd_status;
  assign wr_data   = we && addr == 2'd0;
  assign rd_data   = re && addr == 2'd0;
  assign rd_status = re && addr == 2'd1;

  // ---------------- TX ----------------
  st_t         tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_busy;

  assign tx_busy = tx_st_q != S_IDLE;
  assign txd = (tx_st_q == S_START) ? 1'b0 : (tx_st_q == S_DATA) ? tx_sh_q[0] : 1'b1;

  always_comb begin
    tx_st_d = tx_st_q; tx_cnt_d = tx_cnt_q; tx_div_d = tx_div_q;
    tx_sh_d = tx_sh_q; tx_bit_d = tx_bit_q;
    case (tx_st_q)
      S_IDLE: if (wr_data) begin
        tx_st_d = S_START; tx_cnt_d = '0; tx_div_d = div_q; tx_sh_d = wdata; tx_bit_d = '0;
      end
      S_START: if (tx_cnt_q == tx_div_q) begin
        tx_st_d = S_DATA; tx_cnt_d = '0;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      S_DATA: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0; tx_sh_d = {1'b1, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
        else tx_bit_d = tx_bit_q + 3'd1;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      default: if (tx_cnt_q == tx_div_q) tx_st_d = S_IDLE;
               else tx_cnt_d = tx_cnt_q + 16'd1;
    endcase
  end

  // ---------------- RX ----------------
  st_t         rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_push, ferr_set;

  // (div+1)>>1 without a 17-bit intermediate
  assign rx_half = {1'b0, rx_div_q[15:1]} + {15'd0, rx_div_q[0]};

  always_comb begin
    rx_st_d = rx_st_q; rx_cnt_d = rx_cnt_q; rx_div_d = rx_div_q;
    rx_sh_d = rx_sh_q; rx_bit_d = rx_bit_q;
    rx_push = 1'b0; ferr_set = 1'b0;
    case (rx_st_q)
      S_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d = S_START; rx_cnt_d = '0; rx_div_d = div_q;
      end
      S_START: if (rx_cnt_q == rx_half) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      S_DATA: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d = '0; rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      default: if (rx_cnt_q == rx_div_q) begin
        rx_st_d  = S_IDLE;
        rx_push  = rx_s2_q;
        ferr_set = !rx_s2_q;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
    endcase
  end

  // ---------------- RX buffer ----------------
  logic       empty, pop, push_ok;
  logic [7:0] head;
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [FIFO_DEPTH-1:0][7:0] mem_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   occ_q;
  assign empty   = occ_q == '0;
  assign head    = mem_q[rptr_q];
  assign pop     = rd_data && !empty;
  assign push_ok = rx_push && (occ_q != (AW+1)'(FIFO_DEPTH) || pop);

  always_ff @(posedge clk_i) if (push_ok) mem_q[wptr_q] <= rx_sh_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wptr_q <= '0; rptr_q <= '0; occ_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      occ_q <= occ_q + 1'b1;
      else if (pop && !push_ok) occ_q <= occ_q - 1'b1;
    end
  end
`else
  logic [7:0] hold_q;
  logic       full_q;
  assign empty   = !full_q;
  assign head    = hold_q;
  assign pop     = rd_data && full_q;
  assign push_ok = rx_push && (!full_q || pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      hold_q <= '0; full_q <= 1'b0;
    end else if (push_ok) begin
      hold_q <= rx_sh_q; full_q <= 1'b1;
    end else if (pop) full_q <= 1'b0;
  end
`endif

  // ---------------- bus / flags ----------------
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      case (addr)
        2'd0:    rdata_d = empty ? 8'h00 : head;
        2'd1:    rdata_d = {4'b0, ferr_q, ovr_q, tx_busy, !empty};
        2'd2:    rdata_d = div_q[7:0];
        default: rdata_d = div_q[15:8];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      div_q   <= DIV_RESET; rdata_q <= '0; irq_q <= 1'b0;
      ferr_q  <= 1'b0; ovr_q <= 1'b0;
      tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_div_q <= '0; tx_sh_q <= '0; tx_bit_q <= '0;
      rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_div_q <= '0; rx_sh_q <= '0; rx_bit_q <= '0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
    end else begin
      if (we && addr == 2'd2) div_q[7:0]  <= wdata;
      if (we && addr == 2'd3) div_q[15:8] <= wdata;
      rdata_q <= rdata_d;
      irq_q   <= !empty;
      // a new error in the same cycle as a STATUS read keeps the flag set
      ferr_q  <= ferr_set || (ferr_q && !rd_status);
      ovr_q   <= (rx_push && !push_ok) || (ovr_q && !rd_status);
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d;
      tx_sh_q <= tx_sh_d; tx_bit_q <= tx_bit_d;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d;
      rx_sh_q <= rx_sh_d; rx_bit_q <= rx_bit_d;
      rx_s1_q <= rxd; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;
endmodule
